alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares the single calculator ALU between NumReq requesters (e.g. keypad controller, memory/recall unit).
//  Round-robin grants one transaction at a time, registers its operands/op, and drives the ALU in/out valid-ready handshakes.
//  Routes the result back to the granted requester over its own response handshake; sits between requesters and the ALU.
// PARAMETERS
//  NumReq         2    number of requesters (>=2); index width IdxW = $clog2(NumReq)
//  TimeoutCycles  255  max cycles waiting for alu_in_ready_i before abort; 0 disables timeout
// PORTS
//  clk_i            in   1              clock; all state on rising edge
//  rst_ni           in   1              reset, asynchronous, active-low
//  req_valid_i      in   NumReq         requester i has an operation pending
//  req_ready_o      out  NumReq         arbiter accepts requester i this cycle
//  req_left_i       in   NumReq x num_t left operand per requester (calc_pkg::num_t)
//  req_right_i      in   NumReq x num_t right operand per requester
//  req_op_i         in   NumReq x op_t  operation per requester (calc_pkg::op_t)
//  rsp_valid_o      out  NumReq         response for requester i is presented
//  rsp_ready_i      in   NumReq         requester i consumes its response
//  rsp_result_o     out  num_t          shared result bus, valid where rsp_valid_o[i]=1
//  rsp_error_o      out  1              response is a timeout abort (result '0)
//  alu_left_o       out  num_t          registered left operand to ALU
//  alu_right_o      out  num_t          registered right operand to ALU
//  alu_op_o         out  op_t           registered op to ALU
//  alu_in_valid_o   out  1              operands presented to ALU
//  alu_in_ready_i   in   1              ALU accepts operands
//  alu_out_ready_o  out  1              arbiter accepts ALU result
//  alu_out_valid_i  in   1              ALU result valid
//  alu_result_i     in   num_t          ALU result
//  busy_o           out  1              state != S_IDLE
// BEHAVIOUR
//  Reset (rst_ni=0, async): state=S_IDLE, rr_ptr=0, owner=0, tmo_cnt=0, operand/result regs='0, op reg=OP_ADD, err=0.
//   All valid/ready outputs 0, busy_o=0.
//   A reset mid-transaction discards it; the ALU shares rst_ni so no orphan result follows.
//  Arbitration, S_IDLE only:
//   grant = first i with req_valid_i[i], searching rr_ptr, rr_ptr+1, ... wrapping modulo NumReq.
//   req_ready_o is one-hot at grant (combinational) and 0 in every other state.
//   Handshake: latch left/right/op, owner=grant, tmo_cnt=0, then -> S_ISSUE.
//  S_ISSUE: alu_in_valid_o=1, operands/op held stable.
//   alu_in_ready_i=1 -> S_WAIT.
//   Else tmo_cnt++; if TimeoutCycles!=0 and tmo_cnt==TimeoutCycles-1 -> err=1, result='0, S_RESP (valid dropped; abort).
//  S_WAIT: alu_out_ready_o=1; alu_out_valid_i=1 -> latch alu_result_i, err=0, S_RESP. No timeout in S_WAIT.
//  S_RESP: rsp_valid_o[owner]=1 only; rsp_result_o/rsp_error_o from regs.
//   rsp_ready_i[owner]=1 -> rr_ptr=(owner+1)%NumReq, S_IDLE.
//   rsp_ready_i of non-owners is ignored.
//  Valid/ready signals never combinationally depend on their partner ready/valid, except req_ready_o on req_valid_i.
//  Latency, ALU ready immediately and 1-cycle ALU: req accept t0, alu_in_valid t1, alu_out t2, rsp_valid t3.
//   Earliest next accept is t4 (rsp_ready at t3).
//  Simultaneous requests: exactly one granted per IDLE cycle; the others keep req_valid_i high and wait.
//   Starvation-free: each requester waits at most NumReq-1 transactions.
//  Requester deasserting req_valid_i before the handshake is legal; it is simply not granted.
//  Only one transaction outstanding; the ALU never sees a second in_valid before its result is taken.
// TESTING
//  Single req0 ADD 3+4, ALU 1-cycle -> alu_in_valid t1, rsp_valid_o=2'b01 t3, result 7, err 0, busy_o low t4.
//  req0,req1 both valid from reset -> grant order 0,1,0,1 over 4 transactions; rr_ptr seen 1,0,1,0.
//  alu_in_ready_i held 0, TimeoutCycles=4 -> alu_in_valid_o drops after 4 cycles, rsp_error_o=1, result 0.
//  rsp_ready_i withheld 10 cycles -> rsp_valid_o/result stable; req_ready_o stays 0 for a pending req1.
//  rst_ni pulsed low while in S_WAIT -> all outputs 0 immediately, next req handled from S_IDLE with rr_ptr=0.
//  ALU out_valid delayed 5 cycles, random backpressure -> results match scoreboard per owner, none lost or duplicated.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator datapath types: operand/result width and ALU opcode encoding.
package calc_pkg;

    typedef logic [15:0] num_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

endpackage

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NumReq requesters, one transaction in flight at a time.
// 1-cycle ALU: accept t0, ALU issue t1, ALU result t2, response t3; stalls hold state, ISSUE may time out.
module alu_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic          [NumReq-1:0]        req_valid_i,
    output logic          [NumReq-1:0]        req_ready_o,
    input  calc_pkg::num_t [NumReq-1:0]       req_left_i,
    input  calc_pkg::num_t [NumReq-1:0]       req_right_i,
    input  calc_pkg::op_t  [NumReq-1:0]       req_op_i,
    output logic          [NumReq-1:0]        rsp_valid_o,
    input  logic          [NumReq-1:0]        rsp_ready_i,
    output calc_pkg::num_t                    rsp_result_o,
    output logic                              rsp_error_o,
    output calc_pkg::num_t                    alu_left_o,
    output calc_pkg::num_t                    alu_right_o,
    output calc_pkg::op_t                     alu_op_o,
    output logic                              alu_in_valid_o,
    input  logic                              alu_in_ready_i,
    output logic                              alu_out_ready_o,
    input  logic                              alu_out_valid_i,
    input  calc_pkg::num_t                    alu_result_i,
    output logic                              busy_o
);

    localparam int unsigned IdxW       = $clog2(NumReq);
    localparam int unsigned TmoW       = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam bit          TmoEn      = (TimeoutCycles != 0);
    localparam int unsigned TmoLastInt = TmoEn ? TimeoutCycles - 1 : 0;
    localparam logic [TmoW-1:0] TmoLast = TmoLastInt[TmoW-1:0];

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]      state;
    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] owner;
    logic [TmoW-1:0] tmo_cnt;
    calc_pkg::num_t  left_q;
    calc_pkg::num_t  right_q;
    calc_pkg::op_t   op_q;
    calc_pkg::num_t  result_q;
    logic            err_q;

    logic            grant_vld;
    logic [IdxW-1:0] grant_idx;

    function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                                 input int unsigned     off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NumReq) begin
            sum = sum - NumReq;
        end
        return sum[IdxW-1:0];
    endfunction

    // First pending requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!grant_vld && req_valid_i[wrap_add(rr_ptr, k)]) begin
                grant_vld = 1'b1;
                grant_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == S_IDLE && grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        if (state == S_RESP) begin
            rsp_valid_o[owner] = 1'b1;
        end
    end

    assign rsp_result_o    = result_q;
    assign rsp_error_o     = err_q;
    assign alu_left_o      = left_q;
    assign alu_right_o     = right_q;
    assign alu_op_o        = op_q;
    assign alu_in_valid_o  = (state == S_ISSUE);
    assign alu_out_ready_o = (state == S_WAIT);
    assign busy_o          = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            tmo_cnt  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            op_q     <= calc_pkg::OP_ADD;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        left_q  <= req_left_i[grant_idx];
                        right_q <= req_right_i[grant_idx];
                        op_q    <= req_op_i[grant_idx];
                        owner   <= grant_idx;
                        tmo_cnt <= '0;
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_in_ready_i) begin
                        state <= S_WAIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        // Abort drops in_valid without a handshake; the ALU never saw the operands.
                        if (TmoEn && tmo_cnt == TmoLast) begin
                            err_q    <= 1'b1;
                            result_q <= '0;
                            state    <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (alu_out_valid_i) begin
                        result_q <= alu_result_i;
                        err_q    <= 1'b0;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i[owner]) begin
                        rr_ptr <= wrap_add(owner, 1);
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors, behavioural ALU, decoupled response monitor.
module tb_alu_arbiter;
    import calc_pkg::*;

    typedef struct {
        int   owner;
        num_t result;
        logic err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    num_t [1:0]  req_left, req_right;
    op_t  [1:0]  req_op;
    num_t        rsp_result, alu_left, alu_right, alu_result;
    op_t         alu_op;
    logic        rsp_error, alu_in_valid, alu_in_ready, alu_out_ready, alu_out_valid, busy;

    exp_t exp_q[$];
    int   grant_log[$];
    int   errors = 0, checks = 0;
    int   push_cnt = 0, rsp_cnt = 0, discard_cnt = 0;

    logic [1:0] rsp_en = 2'b11;
    bit         rsp_rand = 0, in_rand = 0, alu_block = 0;
    int         out_lat = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.NumReq(2), .TimeoutCycles(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_left_i(req_left), .req_right_i(req_right), .req_op_i(req_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_error_o(rsp_error),
        .alu_left_o(alu_left), .alu_right_o(alu_right), .alu_op_o(alu_op),
        .alu_in_valid_o(alu_in_valid), .alu_in_ready_i(alu_in_ready),
        .alu_out_ready_o(alu_out_ready), .alu_out_valid_i(alu_out_valid),
        .alu_result_i(alu_result), .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic num_t alu_calc(input op_t op, input num_t a, input num_t b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            default: return (b == 0) ? 16'hFFFF : a / b;
        endcase
    endfunction

    // Behavioural ALU: handshakes observed at negedge, outputs driven just after posedge.
    initial begin
        bit fire_in, fire_out, alu_busy;
        int cnt, in_wait;
        num_t res, cap_l, cap_r;
        op_t cap_op;
        alu_in_ready = 1'b0; alu_out_valid = 1'b0; alu_result = '0;
        alu_busy = 0; cnt = 0; in_wait = 0; res = '0;
        cap_l = '0; cap_r = '0; cap_op = OP_ADD;
        forever begin
            @(negedge clk);
            fire_in  = alu_in_valid && alu_in_ready;
            fire_out = alu_out_valid && alu_out_ready;
            if (fire_in) begin
                cap_l = alu_left; cap_r = alu_right; cap_op = alu_op;
            end
            @(posedge clk); #1;
            if (!rst_n) begin
                alu_in_ready = 1'b0; alu_out_valid = 1'b0; alu_busy = 0; in_wait = 0;
            end else begin
                if (fire_out) begin
                    alu_out_valid = 1'b0;
                    alu_busy = 0;
                    in_wait = in_rand ? $urandom_range(0, 2) : 0;
                end
                if (fire_in) begin
                    alu_busy = 1; cnt = out_lat; res = alu_calc(cap_op, cap_l, cap_r);
                end
                if (alu_busy && !alu_out_valid) begin
                    if (cnt == 0) begin
                        alu_out_valid = 1'b1; alu_result = res;
                    end else begin
                        cnt--;
                    end
                end
                alu_in_ready = !alu_busy && !alu_block && (in_wait == 0);
                if (!alu_busy && in_wait > 0) in_wait--;
            end
        end
    end

    initial begin
        rsp_ready = 2'b00;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++)
                rsp_ready[i] = rsp_en[i] && (!rsp_rand || ($urandom_range(0, 1) == 1));
        end
    end

    // Response monitor: every response handshake pops and checks the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 2; i++) begin
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        rsp_cnt++;
                        if (exp_q.size() == 0) begin
                            check("rsp_unexpected", {31'd0, 1'b1}, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            check($sformatf("rsp_req%0d{owner,result,err}", i),
                                  {8'(i), rsp_result, rsp_error},
                                  {8'(e.owner), e.result, e.err});
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int r, input num_t l, input num_t rt, input op_t op,
                         input num_t exp_res, input logic exp_err);
        int n;
        @(posedge clk); #1;
        req_left[r] = l; req_right[r] = rt; req_op[r] = op; req_valid[r] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[r] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[r]) begin
            check($sformatf("grant_wait_req%0d", r), 64'd0, 64'd1);
            req_valid[r] = 1'b0;
            return;
        end
        exp_q.push_back('{r, exp_res, exp_err});
        grant_log.push_back(r);
        push_cnt++;
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        discard_cnt += exp_q.size();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit stable, rdy_quiet;
        req_valid = '0; req_left = '0; req_right = '0;
        req_op[0] = OP_ADD; req_op[1] = OP_ADD;
        do_reset();

        // Reset state
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_alu_in_valid", alu_in_valid, 0);
        check("rst_alu_out_ready", alu_out_ready, 0);
        check("rst_regs", {rsp_result, rsp_error, alu_left, alu_right, alu_op}, 0);

        // Single ADD 3+4 with 1-cycle ALU, latency checks
        issue(0, 16'd3, 16'd4, OP_ADD, 16'd7, 1'b0);
        @(negedge clk);
        check("t1_alu_in_valid", alu_in_valid, 1);
        check("t1_alu_operands", {alu_left, alu_right, alu_op}, {16'd3, 16'd4, OP_ADD});
        @(negedge clk);
        check("t2_alu_out_ready", alu_out_ready, 1);
        @(negedge clk);
        check("t3_rsp_valid", rsp_valid, 2'b01);
        @(negedge clk);
        check("t4_busy", busy, 0);
        drain("drain_single");

        // Both requesters continuously valid from reset: grants alternate 0,1,0,1
        do_reset();
        grant_log.delete();
        fork
            begin
                issue(0, 16'd10, 16'd3, OP_SUB, 16'd7, 1'b0);
                issue(0, 16'd6, 16'd7, OP_MUL, 16'd42, 1'b0);
            end
            begin
                issue(1, 16'd100, 16'd23, OP_ADD, 16'd123, 1'b0);
                issue(1, 16'd5, 16'd9, OP_SUB, 16'd65532, 1'b0);
            end
        join
        drain("drain_rr");
        check("rr_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("rr_grant0", grant_log[0], 0);
            check("rr_grant1", grant_log[1], 1);
            check("rr_grant2", grant_log[2], 0);
            check("rr_grant3", grant_log[3], 1);
        end

        // ALU never ready: abort after 4 ISSUE cycles with error response
        alu_block = 1;
        issue(1, 16'd1, 16'd1, OP_ADD, 16'd0, 1'b1);
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (alu_in_valid) n++;
        end
        check("tmo_in_valid_cycles", n, 4);
        check("tmo_in_valid_dropped", alu_in_valid, 0);
        alu_block = 0;
        drain("drain_tmo");

        // Response withheld 10 cycles while req1 waits
        rsp_en[0] = 1'b0;
        issue(0, 16'd20, 16'd22, OP_ADD, 16'd42, 1'b0);
        fork
            issue(1, 16'd100, 16'd7, OP_DIV, 16'd14, 1'b0);
            begin
                n = 0;
                while (!rsp_valid[0] && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                check("hold_rsp_seen", rsp_valid[0], 1);
                stable = 1; rdy_quiet = 1;
                repeat (10) begin
                    @(negedge clk);
                    if (!(rsp_valid == 2'b01 && rsp_result == 16'd42 && rsp_error == 1'b0)) stable = 0;
                    if (req_ready != 2'b00) rdy_quiet = 0;
                end
                check("hold_rsp_stable", stable, 1);
                check("hold_req_ready_low", rdy_quiet, 1);
                rsp_en[0] = 1'b1;
            end
        join
        drain("drain_hold");

        // Reset while in S_WAIT, rr_ptr must restart at 0
        issue(0, 16'd1, 16'd2, OP_ADD, 16'd3, 1'b0);
        drain("drain_pre_rst");
        out_lat = 30;
        issue(0, 16'd9, 16'd4, OP_SUB, 16'd5, 1'b0);
        n = 0;
        while (!alu_out_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_in_wait", alu_out_ready, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {req_ready, rsp_valid, alu_in_valid, alu_out_ready, busy,
               rsp_result, rsp_error, alu_left, alu_right, alu_op}, 0);
        discard_cnt += exp_q.size();
        exp_q.delete();
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_lat = 0;
        grant_log.delete();
        fork
            issue(0, 16'd2, 16'd2, OP_ADD, 16'd4, 1'b0);
            issue(1, 16'd3, 16'd3, OP_ADD, 16'd6, 1'b0);
        join
        drain("drain_post_rst");
        check("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

        // Slow ALU with random backpressure on both sides
        out_lat = 5; in_rand = 1; rsp_rand = 1;
        fork
            begin
                issue(0, 16'd1000, 16'd234, OP_ADD, 16'd1234, 1'b0);
                issue(0, 16'd12, 16'd12, OP_MUL, 16'd144, 1'b0);
                issue(0, 16'd50, 16'd5, OP_DIV, 16'd10, 1'b0);
            end
            begin
                issue(1, 16'd300, 16'd1, OP_SUB, 16'd299, 1'b0);
                issue(1, 16'hFFFF, 16'd2, OP_ADD, 16'd1, 1'b0);
                issue(1, 16'd7, 16'd0, OP_DIV, 16'hFFFF, 1'b0);
            end
        join
        drain("drain_random");
        rsp_rand = 0; in_rand = 0; out_lat = 0;
        repeat (5) @(negedge clk);
        check("rsp_count", rsp_cnt, push_cnt - discard_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
